// File: rtl/snow64_scalar_access_arbiter_if.sv
// ----------------------------------------------------------------------------
// snow64_scalar_access_arbiter_if
//
// Bundles the two-requester scalar request bus, the response channel and the
// line-fill port of snow64_scalar_access_arbiter.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A source keeps valid and its payload
// stable until that edge; ready may depend combinationally on valid.
//
// Signals
//   req_valid[i] / req_ready[i]   per-requester request handshake
//   req_is_write[i]               1 = read-modify-write (swap), 0 = read
//   req_line_idx[i]               target line
//   req_data_type[i]              0 uint, 1 sint, 2 BFloat16, 3 reserved
//   req_int_type_size[i]          0 8b, 1 16b, 2 32b, 3 64b
//   req_data_offset[i]            byte offset within the line
//   req_wr_data[i]                scalar to inject (low element bits used)
//   resp_valid / resp_ready       response handshake
//   resp_who / resp_data          answered requester, old element value
//   fill_valid / fill_ready       whole-line write handshake
//   fill_line_idx / fill_data     line to fill and its contents
//
// Modports: master = requester side (scalar units / bench),
//           slave  = arbiter side.
// ----------------------------------------------------------------------------
interface snow64_scalar_access_arbiter_if #(
    parameter int NUM_LINES    = 4,
    parameter int LINE_WIDTH   = 256,
    parameter int SCALAR_WIDTH = 64
) ();
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    logic [1:0]                   req_valid;
    logic [1:0]                   req_ready;
    logic [1:0]                   req_is_write;
    logic [1:0][IDX_W-1:0]        req_line_idx;
    logic [1:0][1:0]              req_data_type;
    logic [1:0][1:0]              req_int_type_size;
    logic [1:0][OFF_W-1:0]        req_data_offset;
    logic [1:0][SCALAR_WIDTH-1:0] req_wr_data;

    logic                         resp_valid;
    logic                         resp_ready;
    logic                         resp_who;
    logic [SCALAR_WIDTH-1:0]      resp_data;

    logic                         fill_valid;
    logic                         fill_ready;
    logic [IDX_W-1:0]             fill_line_idx;
    logic [LINE_WIDTH-1:0]        fill_data;

    modport master (
        output req_valid, req_is_write, req_line_idx, req_data_type,
               req_int_type_size, req_data_offset, req_wr_data,
               resp_ready, fill_valid, fill_line_idx, fill_data,
        input  req_ready, resp_valid, resp_who, resp_data, fill_ready
    );

    modport slave (
        input  req_valid, req_is_write, req_line_idx, req_data_type,
               req_int_type_size, req_data_offset, req_wr_data,
               resp_ready, fill_valid, fill_line_idx, fill_data,
        output req_ready, resp_valid, resp_who, resp_data, fill_ready
    );
endinterface

// File: rtl/snow64_scalar_access_arbiter.sv
// ----------------------------------------------------------------------------
// snow64_scalar_access_arbiter
//
// Shares a small LAR-data line store between two scalar requesters. Each
// granted request goes through one extract/inject datapath: the old element
// is always returned, and a write replaces it in place (swap semantics).
// A separate fill port writes whole lines and has priority over requests.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears store, FSM, response)
//   bus        slave side of snow64_scalar_access_arbiter_if
//   dbg_state  current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Flow: IDLE (fill or grant) -> ACCESS (extract/inject) -> RESP (hold until
// resp_ready) -> IDLE. One request in flight at a time.
// ----------------------------------------------------------------------------
module snow64_scalar_access_arbiter #(
    parameter int NUM_LINES    = 4,
    parameter int LINE_WIDTH   = 256,
    parameter int SCALAR_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    snow64_scalar_access_arbiter_if.slave       bus,
    output logic [1:0]                          dbg_state
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int POS_W = OFF_W + 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, next_state;

    logic                    rr_prio;
    logic                    grant;
    logic                    grant_who;

    logic [LINE_WIDTH-1:0]   lines [NUM_LINES];

    // Request fields captured at the grant edge.
    logic                    lat_who;
    logic                    lat_is_write;
    logic [IDX_W-1:0]        lat_line;
    logic [1:0]              lat_type;
    logic [1:0]              lat_size;
    logic [OFF_W-1:0]        lat_offset;
    logic [SCALAR_WIDTH-1:0] lat_wr_data;

    logic [SCALAR_WIDTH-1:0] resp_data_q;

    // Datapath signals
    logic [1:0]              size_code;
    logic [SCALAR_WIDTH-1:0] elem_mask;
    logic [OFF_W-1:0]        off_mask;
    logic [POS_W-1:0]        bit_pos;
    logic [LINE_WIDTH-1:0]   cur_line;
    logic [LINE_WIDTH-1:0]   wide_mask;
    logic [LINE_WIDTH-1:0]   wide_data;
    logic [SCALAR_WIDTH-1:0] old_elem;
    logic [LINE_WIDTH-1:0]   new_line;

    // ------------------------------------------------------------------
    // Next state, grants and fill acceptance
    // ------------------------------------------------------------------
    always_comb begin
        next_state     = state;
        bus.req_ready  = '0;
        bus.fill_ready = 1'b0;
        grant          = 1'b0;
        grant_who      = rr_prio;
        case (state)
            IDLE: begin
                bus.fill_ready = 1'b1;
                // A pending fill blocks every grant in this cycle.
                if (!bus.fill_valid) begin
                    if (bus.req_valid[rr_prio]) begin
                        grant     = 1'b1;
                        grant_who = rr_prio;
                    end else if (bus.req_valid[~rr_prio]) begin
                        grant     = 1'b1;
                        grant_who = ~rr_prio;
                    end
                end
                if (grant) begin
                    bus.req_ready[grant_who] = 1'b1;
                    next_state               = ACCESS;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    if (bus.resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Extract / inject datapath on the latched request
    // ------------------------------------------------------------------
    always_comb begin
        // BFloat16 is always a 16-bit element.
        size_code = (lat_type == 2'd2) ? 2'd1 : lat_size;
        case (size_code)
            2'd0: begin
                elem_mask = SCALAR_WIDTH'({8{1'b1}});
                off_mask  = OFF_W'(5'b11111);
            end
            2'd1: begin
                elem_mask = SCALAR_WIDTH'({16{1'b1}});
                off_mask  = OFF_W'(5'b11110);
            end
            2'd2: begin
                elem_mask = SCALAR_WIDTH'({32{1'b1}});
                off_mask  = OFF_W'(5'b11100);
            end
            default: begin
                elem_mask = '1;
                off_mask  = OFF_W'(5'b11000);
            end
        endcase
        // index * width == aligned byte offset * 8
        bit_pos   = {lat_offset & off_mask, 3'b000};
        cur_line  = lines[lat_line];
        wide_mask = LINE_WIDTH'(elem_mask) << bit_pos;
        wide_data = LINE_WIDTH'(lat_wr_data & elem_mask) << bit_pos;
        old_elem  = SCALAR_WIDTH'(cur_line >> bit_pos) & elem_mask;
        new_line  = (cur_line & ~wide_mask) | wide_data;
        // Reserved type: reads return zero, writes clear the whole line.
        if (lat_type == 2'd3) begin
            old_elem = '0;
            new_line = '0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_prio      <= 1'b0;
            lat_who      <= 1'b0;
            lat_is_write <= 1'b0;
            lat_line     <= '0;
            lat_type     <= '0;
            lat_size     <= '0;
            lat_offset   <= '0;
            lat_wr_data  <= '0;
            resp_data_q  <= '0;
            for (int i = 0; i < NUM_LINES; i++) lines[i] <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && bus.fill_valid)
                lines[bus.fill_line_idx] <= bus.fill_data;
            if (grant) begin
                // Loser becomes preferred, even if it was not requesting.
                rr_prio      <= ~grant_who;
                lat_who      <= grant_who;
                lat_is_write <= bus.req_is_write[grant_who];
                lat_line     <= bus.req_line_idx[grant_who];
                lat_type     <= bus.req_data_type[grant_who];
                lat_size     <= bus.req_int_type_size[grant_who];
                lat_offset   <= bus.req_data_offset[grant_who];
                lat_wr_data  <= bus.req_wr_data[grant_who];
            end
            if (state == ACCESS) begin
                resp_data_q <= old_elem;
                if (lat_is_write) lines[lat_line] <= new_line;
            end
        end
    end

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_who   = lat_who;
    assign bus.resp_data  = resp_data_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_snow64_scalar_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_snow64_scalar_access_arbiter
//
// Directed bench: a linear sequence of fills, reads, swaps, arbitration,
// backpressure and reset steps with hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_snow64_scalar_access_arbiter;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    snow64_scalar_access_arbiter_if #(
        .NUM_LINES(4), .LINE_WIDTH(256), .SCALAR_WIDTH(64)
    ) bus ();

    snow64_scalar_access_arbiter #(
        .NUM_LINES(4), .LINE_WIDTH(256), .SCALAR_WIDTH(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int who, input logic wr, input logic [1:0] line,
                           input logic [1:0] dtype, input logic [1:0] size,
                           input logic [4:0] off, input logic [63:0] data);
        bus.req_is_write[who]      = wr;
        bus.req_line_idx[who]      = line;
        bus.req_data_type[who]     = dtype;
        bus.req_int_type_size[who] = size;
        bus.req_data_offset[who]   = off;
        bus.req_wr_data[who]       = data;
        bus.req_valid[who]         = 1'b1;
    endtask

    // Bounded wait for requester `who` to be granted; drops its valid after.
    task automatic wait_grant(input int who, input string tag);
        logic got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.req_ready[who]) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_grant"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        bus.req_valid[who] = 1'b0;
    endtask

    // Called right after the handshake edge: response must appear one edge later.
    task automatic expect_resp(input logic who, input logic [63:0] data, input string tag);
        @(negedge clk);
        check({tag, "_lat_valid0"}, 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.resp_valid), 64'd1);
        check({tag, "_who"}, 64'(bus.resp_who), 64'(who));
        check({tag, "_data"}, bus.resp_data, data);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic do_fill(input logic [1:0] line, input logic [255:0] data, input string tag);
        bus.fill_valid    = 1'b1;
        bus.fill_line_idx = line;
        bus.fill_data     = data;
        @(negedge clk);
        check({tag, "_fill_ready"}, 64'(bus.fill_ready), 64'd1);
        @(posedge clk); #1;
        bus.fill_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [255:0] byte_line;
    logic [255:0] line3;
    int           ng;
    int           nr;
    int           last_grant_cyc;

    initial begin
        rst_n                 = 1'b0;
        bus.req_valid         = '0;
        bus.req_is_write      = '0;
        bus.req_line_idx      = '0;
        bus.req_data_type     = '0;
        bus.req_int_type_size = '0;
        bus.req_data_offset   = '0;
        bus.req_wr_data       = '0;
        bus.resp_ready        = 1'b0;
        bus.fill_valid        = 1'b0;
        bus.fill_line_idx     = '0;
        bus.fill_data         = '0;
        for (int i = 0; i < 32; i++) byte_line[i*8 +: 8] = 8'(i);
        line3 = {64'h4444444444444444, 64'h3333333333333333,
                 64'hFEDCBA9876543210, 64'h0123456789ABCDEF};

        // Reset values
        @(negedge clk);
        check("rst_fill_ready", 64'(bus.fill_ready), 64'd1);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_data", bus.resp_data, 64'd0);
        check("rst_resp_who", 64'(bus.resp_who), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: fill line 1 with bytes 0..31, read u8 at offset 5
        do_fill(2'd1, byte_line, "t1");
        set_req(0, 1'b0, 2'd1, 2'd0, 2'd0, 5'd5, 64'd0);
        wait_grant(0, "t1");
        expect_resp(1'b0, 64'h05, "t1_rd8");

        // 2: 32-bit swap at offset 6 -> element 1 = bytes 4..7
        set_req(1, 1'b1, 2'd1, 2'd0, 2'd2, 5'd6, 64'hDEADBEEF);
        wait_grant(1, "t2w");
        expect_resp(1'b1, 64'h07060504, "t2_swap32");
        set_req(1, 1'b0, 2'd1, 2'd0, 2'd3, 5'd0, 64'd0);
        wait_grant(1, "t2r");
        expect_resp(1'b1, 64'hDEADBEEF03020100, "t2_rd64");

        // 3: both valid, resp_ready high -> 0,1,0,1 every 3 cycles (rr_prio = 0)
        set_req(0, 1'b0, 2'd1, 2'd0, 2'd0, 5'd1, 64'd0);
        set_req(1, 1'b0, 2'd1, 2'd0, 2'd0, 5'd2, 64'd0);
        bus.resp_ready = 1'b1;
        ng = 0;
        nr = 0;
        last_grant_cyc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                check("t3_resp_who", 64'(bus.resp_who), 64'(nr % 2));
                check("t3_resp_data", bus.resp_data, (nr % 2 == 0) ? 64'h01 : 64'h02);
                nr++;
            end
            if (bus.req_ready != 2'b00) begin
                check("t3_grant_who", 64'(bus.req_ready), (ng % 2 == 0) ? 64'd1 : 64'd2);
                if (ng > 0) check("t3_grant_gap", 64'(c - last_grant_cyc), 64'd3);
                last_grant_cyc = c;
                ng++;
            end
            @(posedge clk); #1;
            if (ng == 4) bus.req_valid = 2'b00;
        end
        bus.resp_ready = 1'b0;
        check("t3_num_grants", 64'(ng), 64'd4);
        check("t3_num_resps", 64'(nr), 64'd4);

        // 4: fill and request in the same IDLE cycle -> fill first
        bus.fill_valid    = 1'b1;
        bus.fill_line_idx = 2'd3;
        bus.fill_data     = line3;
        set_req(0, 1'b0, 2'd3, 2'd0, 2'd3, 5'd8, 64'd0);
        @(negedge clk);
        check("t4_fill_ready", 64'(bus.fill_ready), 64'd1);
        check("t4_req_blocked", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        bus.fill_valid = 1'b0;
        @(negedge clk);
        check("t4_grant_next", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        expect_resp(1'b0, 64'hFEDCBA9876543210, "t4_rd64");

        // 5: backpressure; rr_prio = 1 so requester 1 wins, 0 waits
        set_req(1, 1'b0, 2'd3, 2'd2, 2'd0, 5'd3, 64'd0);
        set_req(0, 1'b0, 2'd3, 2'd1, 2'd1, 5'd14, 64'd0);
        wait_grant(1, "t5");
        @(negedge clk);
        check("t5_access_no_grant", 64'(bus.req_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(bus.resp_valid), 64'd1);
            check("t5_hold_data", bus.resp_data, 64'h89AB);
            check("t5_hold_who", 64'(bus.resp_who), 64'd1);
            check("t5_hold_no_grant", 64'(bus.req_ready), 64'd0);
            check("t5_hold_no_fill", 64'(bus.fill_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        wait_grant(0, "t5b");
        expect_resp(1'b0, 64'hFEDC, "t5_rd_s16");

        // 6: reserved type on line 2
        do_fill(2'd2, {256{1'b1}}, "t6");
        set_req(0, 1'b0, 2'd2, 2'd0, 2'd0, 5'd31, 64'd0);
        wait_grant(0, "t6a");
        expect_resp(1'b0, 64'hFF, "t6_rd8_ones");
        set_req(1, 1'b1, 2'd2, 2'd3, 2'd0, 5'd0, 64'h1234);
        wait_grant(1, "t6b");
        expect_resp(1'b1, 64'd0, "t6_resv_wr");
        set_req(0, 1'b0, 2'd2, 2'd0, 2'd3, 5'd24, 64'd0);
        wait_grant(0, "t6c");
        expect_resp(1'b0, 64'd0, "t6_line2_zero");
        set_req(1, 1'b0, 2'd1, 2'd3, 2'd3, 5'd0, 64'd0);
        wait_grant(1, "t6d");
        expect_resp(1'b1, 64'd0, "t6_resv_rd");
        set_req(0, 1'b0, 2'd1, 2'd0, 2'd3, 5'd0, 64'd0);
        wait_grant(0, "t6e");
        expect_resp(1'b0, 64'hDEADBEEF03020100, "t6_line1_kept");

        // Reset during ACCESS (rr_prio = 1 before reset)
        set_req(0, 1'b1, 2'd1, 2'd0, 2'd3, 5'd0, 64'hAAAA);
        wait_grant(0, "t6f");
        check("t6_in_access", 64'(dbg_state), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("t6_rst_resp_data", bus.resp_data, 64'd0);
        check("t6_rst_state", 64'(dbg_state), 64'd0);
        set_req(0, 1'b0, 2'd1, 2'd0, 2'd3, 5'd0, 64'd0);
        set_req(1, 1'b0, 2'd3, 2'd0, 2'd3, 5'd8, 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_rst_grant", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        expect_resp(1'b0, 64'd0, "t6_line1_cleared");
        wait_grant(1, "t6g");
        expect_resp(1'b1, 64'd0, "t6_line3_cleared");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
